// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master.
//   spi_mst_state_t : transaction FSM states
//   spi_half()      : system-clock cycles per SCLK half period
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    HOLD,
    GAP
  } spi_mst_state_t;

  function automatic int spi_half(input int fpga_clk, input int spi_clk);
    return fpga_clk / (2 * spi_clk);
  endfunction

endpackage

// File: rtl/bus_if.sv
// Word-wide on-chip valid/ready bus.
//   valid : word present
//   data  : W-bit word
//   ready : consumer can take the word (the master side carries no ready)
interface bus_if #(parameter int W = 16);
  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport slv_port (input valid, input data, output ready);
  modport mst_port (output valid, output data);
endinterface

// File: rtl/spi_if.sv
// SPI pin bundle.
//   sclk : serial clock, driven by the master
//   mosi : master-out serial data
//   miso : master-in serial data
interface spi_if;
  logic sclk;
  logic mosi;
  logic miso;

  modport mst_port (output sclk, output mosi, input miso);
  modport slv_port (input sclk, input mosi, output miso);
endinterface

// File: rtl/spi_clk_div.sv
// Half-period counter for the SPI master.
//   clk, rst : system clock, synchronous active-high reset
//   restart  : hold the counter at zero
//   tick     : high on the last cycle of each HALF-cycle window
module spi_clk_div #(
  parameter int HALF = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == W'(HALF - 1));

  // The counter wraps at every tick; the FSM changes state on every
  // tick, so each state starts with a fresh zero count.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: sends one DATA_SIZE-bit word MSB first on MOSI while
// capturing DATA_SIZE bits from MISO, then returns the received word as a
// one-cycle valid pulse.
//   clk, rst     : system clock, synchronous active-high reset
//   cs           : chip select, active low
//   spi_port     : sclk / mosi out, miso in
//   bus_slv_port : word to transmit (valid/data in, ready out)
//   bus_mst_port : received word (valid/data out, no backpressure)
//
// state | meaning
// IDLE  | ready for a word, cs high
// LOW   | sclk low, mosi carries the current bit
// HIGH  | sclk high, miso sampled on the last cycle
// HOLD  | cs-low hold after the final falling edge
// GAP   | cs high recovery; first cycle pulses the received word
module spi_master import spi_pkg::*; #(
  parameter int DATA_SIZE = 16,
  parameter int FPGA_CLK  = 12_000_000,
  parameter int SPI_CLK   = 1_000_000
) (
  input  logic     clk,
  input  logic     rst,
  output logic     cs,
  spi_if.mst_port  spi_port,
  bus_if.slv_port  bus_slv_port,
  bus_if.mst_port  bus_mst_port
);

  localparam int HALF  = spi_half(FPGA_CLK, SPI_CLK);
  localparam int CNT_W = $clog2(DATA_SIZE + 1);

  if (HALF < 2) begin : g_half_chk
    $error("spi_master: HALF must be at least 2");
  end

  spi_mst_state_t       state_q, state_d;
  logic                 tick;
  logic                 last_bit;
  logic [DATA_SIZE-1:0] tx_q, tx_d;
  logic [DATA_SIZE-1:0] rx_q, rx_d;
  logic [DATA_SIZE-1:0] rdata_q;
  logic [CNT_W-1:0]     bit_q, bit_d;
  logic                 cs_q, sclk_q, mosi_q, rvalid_q;

  spi_clk_div #(.HALF(HALF)) u_clk_div (
    .clk     (clk),
    .rst     (rst),
    .restart (state_q == IDLE),
    .tick    (tick)
  );

  assign last_bit = (bit_q == CNT_W'(DATA_SIZE - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (bus_slv_port.valid) begin
          state_d = LOW;
          tx_d    = bus_slv_port.data;
          rx_d    = '0;
          bit_d   = '0;
        end
      end
      LOW: begin
        if (tick) state_d = HIGH;
      end
      HIGH: begin
        if (tick) begin
          rx_d    = {rx_q[DATA_SIZE-2:0], spi_port.miso};
          tx_d    = tx_q << 1;
          bit_d   = bit_q + CNT_W'(1);
          state_d = last_bit ? HOLD : LOW;
        end
      end
      HOLD: begin
        if (tick) state_d = GAP;
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they change only at
  // clock edges and always agree with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q     <= '0;
      rx_q     <= '0;
      bit_q    <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      rvalid_q <= 1'b0;
      // A reset that lands mid-transaction keeps the last good word; only
      // a reset seen while idle (e.g. power-up) clears it.
      if (state_q == IDLE) rdata_q <= '0;
    end else begin
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      bit_q    <= bit_d;
      cs_q     <= !(state_d inside {LOW, HIGH, HOLD});
      sclk_q   <= (state_d == HIGH);
      rvalid_q <= (state_q == HOLD) && (state_d == GAP);
      if ((state_d == LOW) && (state_q != LOW)) mosi_q <= tx_d[DATA_SIZE-1];
      if ((state_q == HOLD) && (state_d == GAP)) rdata_q <= rx_q;
    end
  end

  assign cs                 = cs_q;
  assign spi_port.sclk      = sclk_q;
  assign spi_port.mosi      = mosi_q;
  assign bus_slv_port.ready = (state_q == IDLE);
  assign bus_mst_port.valid = rvalid_q;
  assign bus_mst_port.data  = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs;
  int          mode = 0;          // 0 loopback, 1 miso=0, 2 miso=1, 3 pattern
  logic        miso_drv = 1'b0;
  logic [15:0] last_rx = 16'h0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  spi_if          spi ();
  bus_if #(.W(16)) bin ();
  bus_if #(.W(16)) bout ();

  assign spi.miso = (mode == 0) ? spi.mosi : miso_drv;

  spi_master #(.DATA_SIZE(16), .FPGA_CLK(12_000_000), .SPI_CLK(1_000_000)) dut (
    .clk          (clk),
    .rst          (rst),
    .cs           (cs),
    .spi_port     (spi),
    .bus_slv_port (bin),
    .bus_mst_port (bout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One transaction, observed cycle by cycle from T+1 (T = accept cycle).
  // Expected timing from the rules: cs low T+1..T+198, rises at T+7+12*i,
  // valid pulse at T+199, ready back at T+205.
  task automatic txn(input logic [15:0] w, input int md, input logic [15:0] pat,
                     input int rst_at, input int inj_at, input bit hold_next,
                     input logic [15:0] next_w, input bit skip_acc);
    logic        sc [0:210];
    logic        cv [0:210];
    logic        mo [0:210];
    logic        rd [0:210];
    logic        vv [0:210];
    logic [15:0] vd [0:210];
    logic [15:0] exp_rx, mbits, vdata;
    int win, guard, ri, first_lo, last_lo, rises, pos_bad, ph_bad, nruns, run;
    int setup_bad, mchg_bad, rdy_bad, vcount, vk, cs_hi;

    exp_rx = (md == 0) ? w : (md == 1) ? 16'h0000 : (md == 2) ? 16'hFFFF : pat;
    win = hold_next ? 205 : 210;

    if (!skip_acc) begin
      guard = 0;
      @(negedge clk);
      while (!bin.ready && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      chk("ready_wait", {31'b0, bin.ready}, 32'd1);
      mode     = md;
      miso_drv = (md == 2);
      bin.data = w;
      bin.valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if (hold_next) bin.data = next_w;
    else           bin.valid = 1'b0;

    sc[0] = 1'b0; cv[0] = 1'b1; mo[0] = spi.mosi; rd[0] = 1'b0; vv[0] = 1'b0; vd[0] = 16'h0;
    ri = 0;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if (rst_at > 0 && k == rst_at) rst = 1'b1;
      if (rst_at > 0 && k == rst_at + 1) begin
        chk("rst_cs", {31'b0, cs}, 32'd1);
        chk("rst_sclk", {31'b0, spi.sclk}, 32'd0);
        rst = 1'b0;
      end
      if (inj_at > 0 && k == inj_at) begin
        bin.data  = 16'h5555;
        bin.valid = 1'b1;
      end
      if (inj_at > 0 && k == inj_at + 1) bin.valid = 1'b0;
      sc[k] = spi.sclk; cv[k] = cs; mo[k] = spi.mosi;
      rd[k] = bin.ready; vv[k] = bout.valid; vd[k] = bout.data;
      if (md == 3 && sc[k] && !sc[k-1] && !cv[k] && ri < 16) begin
        miso_drv = pat[15-ri];
        ri++;
      end
    end

    vcount = 0; vk = -1; vdata = 16'h0;
    for (int k = 1; k <= win; k++)
      if (vv[k]) begin
        vcount++;
        if (vk < 0) begin vk = k; vdata = vd[k]; end
      end

    if (rst_at > 0) begin
      cs_hi = 0;
      for (int k = rst_at + 1; k <= win; k++) if (cv[k]) cs_hi++;
      chk("rst_no_valid", vcount, 0);
      chk("rst_data_kept", {16'h0, vd[win]}, {16'h0, last_rx});
      chk("rst_cs_stays_high", cs_hi, win - rst_at);
      chk("rst_ready", {31'b0, rd[rst_at+1]}, 32'd1);
      return;
    end

    first_lo = -1; last_lo = -1;
    for (int k = 1; k <= win; k++)
      if (!cv[k]) begin
        if (first_lo < 0) first_lo = k;
        last_lo = k;
      end
    chk("cs_fall", first_lo, 1);
    chk("cs_last_low", last_lo, 198);
    cs_hi = 0;
    for (int k = 199; k <= 205; k++) if (cv[k]) cs_hi++;
    chk("cs_gap", cs_hi, 7);

    rises = 0; pos_bad = 0; setup_bad = 0; mbits = 16'h0;
    for (int k = 1; k <= win; k++)
      if (sc[k] && !sc[k-1] && !cv[k]) begin
        if (k != 7 + 12 * rises) pos_bad++;
        for (int j = k - 6; j < k; j++) if (j < 1 || mo[j] !== mo[k]) setup_bad++;
        mbits = {mbits[14:0], mo[k]};
        rises++;
      end
    chk("rise_count", rises, 16);
    chk("rise_pos", pos_bad, 0);
    chk("mosi_bits", {16'h0, mbits}, {16'h0, w});
    chk("mosi_setup", setup_bad, 0);

    mchg_bad = 0;
    for (int k = 2; k <= win; k++) if (sc[k] && mo[k] !== mo[k-1]) mchg_bad++;
    chk("mosi_in_high", mchg_bad, 0);

    ph_bad = 0; nruns = 0; run = 1;
    if (first_lo > 0) begin
      for (int k = first_lo + 1; k <= last_lo; k++) begin
        if (sc[k] == sc[k-1]) run++;
        else begin
          nruns++;
          if (run != 6) ph_bad++;
          run = 1;
        end
      end
      nruns++;
      if (run != 6) ph_bad++;
    end
    chk("phase_len", ph_bad, 0);
    chk("phase_count", nruns, 33);

    chk("valid_count", vcount, 1);
    chk("valid_cycle", vk, 199);
    chk("rx_data", {16'h0, vdata}, {16'h0, exp_rx});
    chk("rx_held", {16'h0, vd[win]}, {16'h0, exp_rx});

    rdy_bad = 0;
    for (int k = 1; k <= 204; k++) if (rd[k]) rdy_bad++;
    chk("ready_busy", rdy_bad, 0);
    chk("ready_back", {31'b0, rd[205]}, 32'd1);
    last_rx = exp_rx;
  endtask

  initial begin
    logic [15:0] w, p;
    int md;
    bin.valid = 1'b0;
    bin.data  = 16'h0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cs", {31'b0, cs}, 32'd1);
    chk("reset_sclk", {31'b0, spi.sclk}, 32'd0);
    chk("reset_mosi", {31'b0, spi.mosi}, 32'd0);
    chk("reset_valid", {31'b0, bout.valid}, 32'd0);
    chk("reset_data", {16'h0, bout.data}, 32'd0);
    chk("reset_ready", {31'b0, bin.ready}, 32'd1);

    txn(16'hA5C3, 0, 16'h0, 0, 0, 1'b0, 16'h0, 1'b0);
    txn(16'h0000, 2, 16'h0, 0, 0, 1'b0, 16'h0, 1'b0);
    txn(16'h1234, 0, 16'h0, 0, 0, 1'b1, 16'hBEEF, 1'b0);
    txn(16'hBEEF, 0, 16'h0, 0, 0, 1'b0, 16'h0, 1'b1);
    txn(16'h00FF, 0, 16'h0, 0, 50, 1'b0, 16'h0, 1'b0);
    txn(16'hC3C3, 0, 16'h0, 100, 0, 1'b0, 16'h0, 1'b0);
    txn(16'h8001, 0, 16'h0, 0, 0, 1'b0, 16'h0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      w  = 16'($urandom);
      p  = 16'($urandom);
      md = int'($urandom_range(0, 3));
      txn(w, md, p, 0, 0, 1'b0, 16'h0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
